aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencing FSM for the AES-128 encryption datapath.
- Drives the subbytes byteenable gate and waits out the synchronous S-box latency.
- Steers the state-register mux and write-enable, steps the key schedule, and counts rounds.
- Provides a start/done handshake to the SPI/top-level wrapper; it contains control only, no 128-bit data.

Parameters:
- NROUNDS, 10, number of AES rounds (AES-128); legal range 1..15.
- SBOX_LAT, 1, read latency in clock cycles of the synchronous S-box path (input to valid output); must be >= 1.

Ports:
- int_osc  input  1  system clock, all flops rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level request; sampled only in IDLE.
- byteenable  output  1  gates the S-box inputs (0 forces them to zero).
- state_we  output  1  state-register write enable.
- state_sel  output  1  state mux select: 0 = plaintext XOR key0, 1 = round result.
- mix_bypass  output  1  skip MixColumns (final round).
- key_load  output  1  load cipher key into the round-key register.
- key_step  output  1  advance the key schedule by one round.
- round  output  4  current round number, 0..NROUNDS.
- busy  output  1  high in INIT, SUB and RND.
- done  output  1  ciphertext valid in the state register.

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, lat_cnt=0, round=0, and every output is 0. A reset mid-operation aborts immediately; the datapath contents are don't-care.
- The FSM has five states: IDLE, INIT, SUB, RND, DONE.
- All outputs are registered-state decodes (Moore); none depend combinationally on start.
- IDLE: all outputs 0. If start=1 at a clock edge, go to INIT.
- INIT (1 cycle): state_we=1, state_sel=0, key_load=1, round=0. Next state is SUB, with round<=1 and lat_cnt<=0.
- SUB (SBOX_LAT cycles): byteenable=1. lat_cnt increments each cycle. When lat_cnt==SBOX_LAT-1, go to RND.
- RND (1 cycle): byteenable=1 (held so the S-box output stays stable), state_we=1, state_sel=1, key_step=1, mix_bypass=(round==NROUNDS).
  - If round==NROUNDS, go to DONE.
  - Otherwise round<=round+1, lat_cnt<=0, and go to SUB.
- DONE: done=1, busy=0, round holds NROUNDS. Stay in DONE while start=1; go to IDLE on start=0.
  - done therefore remains high until start is released. Holding start high never retriggers an encryption.
- start changes while busy are ignored.
- Latency: let the INIT cycle be cycle 0. The final RND is cycle NROUNDS*(SBOX_LAT+1), and done first goes high on the cycle after it. Defaults give final RND at cycle 20 and done at cycle 21.
- Per round: byteenable is high for exactly SBOX_LAT+1 consecutive cycles, and state_we pulses once.
- byteenable is low in INIT, so the S-boxes never see stale data while the state register loads.
- round never exceeds NROUNDS and never wraps. lat_cnt is sized by $clog2(SBOX_LAT+1).
- Elaboration: an assertion fails if SBOX_LAT<1 or NROUNDS is not in 1..15.

Decomposition:
- Shared package aes_pkg holds:
  - typedef enum logic [2:0] ctrl_state_t {IDLE, INIT, SUB, RND, DONE};
  - constant AES128_NROUNDS=10;
  - state_sel encodings SEL_INIT=1'b0, SEL_ROUND=1'b1.
- No sub-module: the latency counter and round counter are small enough to stay inline.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, start=0 for 10 cycles -> every output stays 0, round=0.
- Nominal run (defaults): start=1 held -> INIT at cycle 0 with key_load=1 and state_we=1. Then 10 state_we pulses in RND at cycles 2,4,...,20; byteenable is high on cycles 1-20; mix_bypass=1 only at cycle 20; done=1 from cycle 21.
- Handshake: keep start=1 for 5 cycles after done -> done held and no new INIT. Drop start -> IDLE next cycle. Re-raise start -> new INIT with round=0.
- SBOX_LAT=3, NROUNDS=10: each round has byteenable high for 4 cycles and one state_we -> final RND at cycle 40, done at 41.
- Reset mid-run: pull reset low during round 5 SUB -> all outputs 0 asynchronously, before the next clock edge. After release, a start gives a full fresh 21-cycle run from INIT.
- Start glitch while busy: toggle start 1-0-1 during rounds 2-4 -> round sequence and timing identical to the nominal run.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round controller.
// Latency: n/a (declarations only). Backpressure: n/a.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SUB,
        RND,
        DONE
    } ctrl_state_t;

    localparam int AES128_NROUNDS = 10;

    localparam logic SEL_INIT  = 1'b0;
    localparam logic SEL_ROUND = 1'b1;

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 datapath: gates S-boxes, steers state mux, steps key schedule.
// Latency: INIT at cycle 0, final RND at NROUNDS*(SBOX_LAT+1), done on the cycle after.
// Backpressure: none; start is a level request sampled in IDLE, done holds until start drops.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NROUNDS  = AES128_NROUNDS,
    parameter int SBOX_LAT = 1
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       start,
    output logic       byteenable,
    output logic       state_we,
    output logic       state_sel,
    output logic       mix_bypass,
    output logic       key_load,
    output logic       key_step,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);

    localparam int              LW         = $clog2(SBOX_LAT + 1);
    localparam logic [LW-1:0]   LAT_LAST   = LW'(SBOX_LAT - 1);
    localparam logic [3:0]      ROUND_LAST = 4'(NROUNDS);

    if (SBOX_LAT < 1 || NROUNDS < 1 || NROUNDS > 15) begin : g_param_check
        $error("aes_round_ctrl: SBOX_LAT must be >= 1 and NROUNDS in 1..15");
    end

    ctrl_state_t   state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [3:0]    round_q, round_d;

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            round_q   <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            round_q   <= round_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        round_d   = round_q;
        case (state_q)
            IDLE: begin
                round_d   = '0;
                lat_cnt_d = '0;
                if (start) state_d = INIT;
            end
            INIT: begin
                state_d   = SUB;
                round_d   = 4'd1;
                lat_cnt_d = '0;
            end
            SUB: begin
                // S-box output is valid once the latency count reaches its last value
                if (lat_cnt_q == LAT_LAST) state_d = RND;
                else                       lat_cnt_d = lat_cnt_q + LW'(1);
            end
            RND: begin
                if (round_q == ROUND_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d   = SUB;
                    round_d   = round_q + 4'd1;
                    lat_cnt_d = '0;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                round_d   = '0;
                lat_cnt_d = '0;
            end
        endcase
    end

    // Moore decodes; byteenable stays high through RND so the captured S-box result is stable
    assign byteenable = (state_q == SUB) || (state_q == RND);
    assign state_we   = (state_q == INIT) || (state_q == RND);
    assign state_sel  = (state_q == RND) ? SEL_ROUND : SEL_INIT;
    assign mix_bypass = (state_q == RND) && (round_q == ROUND_LAST);
    assign key_load   = (state_q == INIT);
    assign key_step   = (state_q == RND);
    assign busy       = (state_q == INIT) || (state_q == SUB) || (state_q == RND);
    assign done       = (state_q == DONE);
    assign round      = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: default instance plus an SBOX_LAT=3 instance, each checked every cycle
// against a cycle-offset arithmetic model, with table vectors and directed corner sequences.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int LA = 1;
    localparam int LB = 3;

    typedef struct packed {
        logic       be;
        logic       we;
        logic       sel;
        logic       mb;
        logic       kl;
        logic       ks;
        logic [3:0] rnd;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct {
        int    t;
        logic  start;
        outs_t exp;
    } vec_t;

    logic int_osc = 1'b0;
    always #5 int_osc = ~int_osc;

    logic reset_a = 1'b1, start_a = 1'b0;
    logic reset_b = 1'b1, start_b = 1'b0;

    logic       be_a, we_a, sel_a, mb_a, kl_a, ks_a, busy_a, done_a;
    logic [3:0] rnd_a;
    logic       be_b, we_b, sel_b, mb_b, kl_b, ks_b, busy_b, done_b;
    logic [3:0] rnd_b;

    aes_round_ctrl dut (
        .int_osc(int_osc), .reset(reset_a), .start(start_a),
        .byteenable(be_a), .state_we(we_a), .state_sel(sel_a), .mix_bypass(mb_a),
        .key_load(kl_a), .key_step(ks_a), .round(rnd_a), .busy(busy_a), .done(done_a)
    );

    aes_round_ctrl #(.NROUNDS(NR), .SBOX_LAT(LB)) dut3 (
        .int_osc(int_osc), .reset(reset_b), .start(start_b),
        .byteenable(be_b), .state_we(we_b), .state_sel(sel_b), .mix_bypass(mb_b),
        .key_load(kl_b), .key_step(ks_b), .round(rnd_b), .busy(busy_b), .done(done_b)
    );

    outs_t act_a, act_b;
    assign act_a = {be_a, we_a, sel_a, mb_a, kl_a, ks_a, rnd_a, busy_a, done_a};
    assign act_b = {be_b, we_b, sel_b, mb_b, kl_b, ks_b, rnd_b, busy_b, done_b};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string nm, input outs_t act, input outs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected outputs from the operation mode (0 idle, 1 running, 2 done) and the cycle offset from INIT.
    function automatic outs_t model_out(input int mode, input int t, input int n, input int l);
        outs_t o;
        int    r, ph;
        o = '0;
        if (mode == 2) begin
            o.done = 1'b1;
            o.rnd  = 4'(n);
        end else if (mode == 1) begin
            o.busy = 1'b1;
            if (t == 0) begin
                o.we = 1'b1;
                o.kl = 1'b1;
            end else begin
                r     = (t - 1) / (l + 1) + 1;
                ph    = (t - 1) % (l + 1);
                o.be  = 1'b1;
                o.rnd = 4'(r);
                if (ph == l) begin
                    o.we  = 1'b1;
                    o.sel = 1'b1;
                    o.ks  = 1'b1;
                    o.mb  = (r == n);
                end
            end
        end
        return o;
    endfunction

    int mode_a = 0, t_a = 0;
    int mode_b = 0, t_b = 0;

    always @(posedge int_osc or negedge reset_a) begin
        if (!reset_a) begin
            mode_a <= 0;
            t_a    <= 0;
        end else if (mode_a == 0) begin
            if (start_a) begin
                mode_a <= 1;
                t_a    <= 0;
            end
        end else if (mode_a == 1) begin
            if (t_a == NR * (LA + 1)) mode_a <= 2;
            else                      t_a <= t_a + 1;
        end else if (!start_a) begin
            mode_a <= 0;
        end
    end

    always @(posedge int_osc or negedge reset_b) begin
        if (!reset_b) begin
            mode_b <= 0;
            t_b    <= 0;
        end else if (mode_b == 0) begin
            if (start_b) begin
                mode_b <= 1;
                t_b    <= 0;
            end
        end else if (mode_b == 1) begin
            if (t_b == NR * (LB + 1)) mode_b <= 2;
            else                      t_b <= t_b + 1;
        end else if (!start_b) begin
            mode_b <= 0;
        end
    end

    always @(negedge int_osc) begin
        cyc <= cyc + 1;
        check("model_a", act_a, model_out(mode_a, t_a, NR, LA));
        check("model_b", act_b, model_out(mode_b, t_b, NR, LB));
    end

    vec_t tbl[8];

    initial begin
        int done_k, we_cnt, be_cnt, mb_k;

        tbl[0] = '{t: 0,  start: 1'b1, exp: '{be:0, we:1, sel:0, mb:0, kl:1, ks:0, rnd:4'd0,  busy:1, done:0}};
        tbl[1] = '{t: 1,  start: 1'b1, exp: '{be:1, we:0, sel:0, mb:0, kl:0, ks:0, rnd:4'd1,  busy:1, done:0}};
        tbl[2] = '{t: 2,  start: 1'b1, exp: '{be:1, we:1, sel:1, mb:0, kl:0, ks:1, rnd:4'd1,  busy:1, done:0}};
        tbl[3] = '{t: 3,  start: 1'b1, exp: '{be:1, we:0, sel:0, mb:0, kl:0, ks:0, rnd:4'd2,  busy:1, done:0}};
        tbl[4] = '{t: 19, start: 1'b1, exp: '{be:1, we:0, sel:0, mb:0, kl:0, ks:0, rnd:4'd10, busy:1, done:0}};
        tbl[5] = '{t: 20, start: 1'b1, exp: '{be:1, we:1, sel:1, mb:1, kl:0, ks:1, rnd:4'd10, busy:1, done:0}};
        tbl[6] = '{t: 21, start: 1'b1, exp: '{be:0, we:0, sel:0, mb:0, kl:0, ks:0, rnd:4'd10, busy:0, done:1}};
        tbl[7] = '{t: 26, start: 1'b1, exp: '{be:0, we:0, sel:0, mb:0, kl:0, ks:0, rnd:4'd10, busy:0, done:1}};

        // Reset then idle
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (3) @(negedge int_osc);
        reset_a = 1'b1;
        reset_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge int_osc);
            check("idle_a", act_a, '0);
        end

        // Nominal run driven from the vector table, including the held-start handshake
        start_a = tbl[0].start;
        for (int k = 0; k <= 26; k++) begin
            @(negedge int_osc);
            for (int i = 0; i < 8; i++)
                if (tbl[i].t == k) check($sformatf("vec_t%0d", k), act_a, tbl[i].exp);
        end
        start_a = 1'b0;
        @(negedge int_osc);
        check("drop_to_idle", act_a, '0);
        start_a = 1'b1;
        @(negedge int_osc);
        check("restart_init", act_a, tbl[0].exp);
        repeat (25) @(negedge int_osc);
        start_a = 1'b0;
        repeat (2) @(negedge int_osc);

        // SBOX_LAT=3 instance: timing and pulse counts
        done_k = -1; we_cnt = 0; be_cnt = 0; mb_k = -1;
        start_b = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge int_osc);
            if (done_b && done_k < 0) done_k = k;
            if (we_b && sel_b) we_cnt++;
            if (be_b) be_cnt++;
            if (mb_b) mb_k = k;
        end
        check_int("lat3_done_cycle", done_k, 41);
        check_int("lat3_round_we", we_cnt, 10);
        check_int("lat3_be_cycles", be_cnt, 40);
        check_int("lat3_bypass_cycle", mb_k, 40);
        start_b = 1'b0;
        repeat (2) @(negedge int_osc);

        // Reset during round 5 SUB must clear outputs before the next edge
        start_a = 1'b1;
        for (int k = 0; k <= 9; k++) @(negedge int_osc);
        check_int("round5_before_reset", int'(rnd_a), 5);
        #2 reset_a = 1'b0;
        #1 check("async_reset", act_a, '0);
        start_a = 1'b0;
        @(negedge int_osc);
        reset_a = 1'b1;
        @(negedge int_osc);
        done_k = -1;
        start_a = 1'b1;
        for (int k = 0; k < 100 && done_k < 0; k++) begin
            @(negedge int_osc);
            if (done_a) done_k = k;
        end
        check_int("fresh_run_done", done_k, 21);
        start_a = 1'b0;
        repeat (2) @(negedge int_osc);

        // Start glitching while busy must not disturb the run
        done_k = -1; we_cnt = 0;
        start_a = 1'b1;
        for (int k = 0; k < 100 && done_k < 0; k++) begin
            @(negedge int_osc);
            if (done_a) done_k = k;
            if (we_a) we_cnt++;
            if (k >= 3 && k <= 8) start_a = (k % 2 == 0);
            else                  start_a = 1'b1;
        end
        check_int("glitch_done", done_k, 21);
        check_int("glitch_we", we_cnt, 11);
        start_a = 1'b0;
        repeat (2) @(negedge int_osc);

        // Random start/reset traffic on both instances, checked by the per-cycle model
        for (int i = 0; i < 600; i++) begin
            @(negedge int_osc);
            if ($urandom_range(0, 7) == 0) start_a = ~start_a;
            if ($urandom_range(0, 7) == 0) start_b = ~start_b;
            reset_a = ($urandom_range(0, 99) != 0);
            reset_b = ($urandom_range(0, 99) != 0);
        end
        reset_a = 1'b1;
        reset_b = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (50) @(negedge int_osc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
